// File: rtl/bf_pkg.sv
// Shared types and constants for the beamformer channel datapath.
// Holds the delay-line sequencer state encoding and BRAM geometry.
package bf_pkg;

   localparam int unsigned DLY_ADDR_W  = 3;
   localparam int unsigned BRAM_RD_LAT = 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StRun   = 2'd2,
      StDrain = 2'd3
   } dly_state_t;

endpackage

// File: rtl/bram_delay_ctrl.sv
// Circular-buffer sequencer for a dual-port BRAM delay line: each sample is
// read back exactly `delay` input samples after it was written.
module bram_delay_ctrl
   import bf_pkg::*;
#(
   parameter int unsigned ADDR_W = DLY_ADDR_W,
   parameter int unsigned RD_LAT = BRAM_RD_LAT
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [ADDR_W-1:0] cfg_delay,
   output logic              cfg_ready,
   input  logic              start,
   input  logic              stop,
   input  logic              sample_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              out_valid,
   output logic              busy
);

   dly_state_t        state_q;
   logic [ADDR_W-1:0] delay_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W-1:0] occ_q;
   logic              busy_q;
   logic              cfg_ready_q;
   logic [RD_LAT-1:0] vld_q;
   logic [ADDR_W-1:0] occ_inc;

   assign occ_inc   = occ_q + ADDR_W'(1);
   assign wr_addr   = wr_ptr_q;
   assign rd_addr   = rd_ptr_q;
   assign busy      = busy_q;
   assign cfg_ready = cfg_ready_q;
   assign out_valid = vld_q[RD_LAT-1];

   // Enables are combinational so they line up with the sample on the BRAM data bus.
   always_comb begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      unique case (state_q)
         StFill: wr_en = sample_valid;
         StRun: begin
            wr_en = sample_valid;
            rd_en = sample_valid;
         end
         StDrain: rd_en = (occ_q != '0);
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         delay_q     <= ADDR_W'(1);
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cfg_valid) begin
                  delay_q <= (cfg_delay == '0) ? ADDR_W'(1) : cfg_delay;
               end
               if (start) begin
                  wr_ptr_q    <= '0;
                  rd_ptr_q    <= '0;
                  occ_q       <= '0;
                  state_q     <= StFill;
                  busy_q      <= 1'b1;
                  cfg_ready_q <= 1'b0;
               end
            end
            StFill: begin
               if (sample_valid) begin
                  wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                  occ_q    <= occ_inc;
               end
               if (stop) begin
                  // Nothing buffered and nothing arriving: no drain needed.
                  if (!sample_valid && occ_q == '0) begin
                     state_q     <= StIdle;
                     busy_q      <= 1'b0;
                     cfg_ready_q <= 1'b1;
                  end else begin
                     state_q <= StDrain;
                  end
               end else if (sample_valid && occ_inc == delay_q) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (sample_valid) begin
                  wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
               end
               if (stop) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (occ_q != '0) begin
                  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                  occ_q    <= occ_q - ADDR_W'(1);
               end
               if (occ_q <= ADDR_W'(1)) begin
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  cfg_ready_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Read-enable pipeline matching the BRAM read latency.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= RD_LAT'({vld_q, rd_en});
      end
   end

endmodule
